// File: rtl/face_scale_sched.sv
// rtl/face_scale_sched.sv - per-frame pyramid scale scheduler for the face detection cascade
// Optional per-scale watchdog: define FACE_SCALE_TIMEOUT_EN.
module face_scale_sched #(
  parameter int N_SCALES = 5,
  parameter int W_DIM    = 16,
  parameter int WIN_SIZE = 24,
  parameter int TIMEOUT  = 2**20
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [2:0]                max_scale_cnt,
  input  logic [N_SCALES*8-1:0]     scale_factor,
  input  logic [N_SCALES*W_DIM-1:0] pic_w_all,
  input  logic [N_SCALES*W_DIM-1:0] pic_h_all,
  input  logic                      frame_start,
  input  logic                      scale_done,
  output logic                      scale_start,
  output logic [2:0]                scale_idx,
  output logic [W_DIM-1:0]          cur_w,
  output logic [W_DIM-1:0]          cur_h,
  output logic [7:0]                cur_factor,
  output logic                      busy,
  output logic                      frame_ready,
  output logic                      frame_drop,
  output logic                      timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_NEXT, S_DONE
  } state_t;

  localparam logic [W_DIM-1:0] WIN = W_DIM'(WIN_SIZE);

  state_t           state, state_nxt;
  logic [2:0]       n_eff, n_eff_in;
  logic [W_DIM-1:0] sel_w, sel_h;
  logic [7:0]       sel_f;
  logic             skip, last_scale, accept, to_hit;

  assign sel_w      = pic_w_all[W_DIM*scale_idx +: W_DIM];
  assign sel_h      = pic_h_all[W_DIM*scale_idx +: W_DIM];
  assign sel_f      = scale_factor[8*scale_idx +: 8];
  assign skip       = (sel_w < WIN) || (sel_h < WIN);
  assign last_scale = (scale_idx == n_eff - 3'd1);
  assign accept     = frame_start && en && (state == S_IDLE);

  // Scale count is clamped to 1..N_SCALES; zero still runs the base level.
  always_comb begin
    n_eff_in = max_scale_cnt;
    if (max_scale_cnt == 3'd0)
      n_eff_in = 3'd1;
    else if (32'(max_scale_cnt) > 32'(N_SCALES))
      n_eff_in = 3'(N_SCALES);
  end

`ifdef FACE_SCALE_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT - 1);
  logic [31:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rstn)
      to_cnt <= '0;
    else if (state == S_START)
      to_cnt <= '0;
    else if (state == S_RUN)
      to_cnt <= to_cnt + 32'd1;
  end

  // A scale_done arriving on the limit cycle takes precedence over the abort.
  assign to_hit = (state == S_RUN) && (to_cnt == TO_LIM) && !scale_done;
`else
  assign to_hit = 1'b0;
`endif

  assign timeout_err = to_hit;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= S_IDLE;
      n_eff      <= 3'd1;
      scale_idx  <= '0;
      cur_w      <= '0;
      cur_h      <= '0;
      cur_factor <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        n_eff     <= n_eff_in;
        scale_idx <= '0;
      end
      if (state == S_LOAD) begin
        cur_w      <= sel_w;
        cur_h      <= sel_h;
        cur_factor <= sel_f;
      end
      if (state == S_NEXT && !last_scale)
        scale_idx <= scale_idx + 3'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    scale_start = 1'b0;
    frame_ready = 1'b0;
    busy        = (state != S_IDLE);
    frame_drop  = frame_start && (state != S_IDLE);
    case (state)
      S_IDLE:  if (frame_start && en) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = skip ? S_NEXT : S_START;
      S_START: begin
        scale_start = 1'b1;
        state_nxt   = S_RUN;
      end
      S_RUN:   if (scale_done || to_hit) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_scale ? S_DONE : S_LOAD;
      S_DONE:  begin
        frame_ready = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_face_scale_sched.sv
// tb/tb_face_scale_sched.sv - self-checking bench for face_scale_sched
// Timeline model per frame, per-cycle compare at negedge, directed scenarios with literal pins.
module tb_face_scale_sched;

  localparam int N = 5;
  localparam int W = 16;
  localparam int T = 64;
`ifdef FACE_SCALE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rstn, en, frame_start, scale_done;
  logic [2:0]     max_scale_cnt;
  logic [N*8-1:0] scale_factor;
  logic [N*W-1:0] pic_w_all, pic_h_all;
  logic           scale_start, busy, frame_ready, frame_drop, timeout_err;
  logic [2:0]     scale_idx;
  logic [W-1:0]   cur_w, cur_h;
  logic [7:0]     cur_factor;

  face_scale_sched #(.N_SCALES(N), .W_DIM(W), .WIN_SIZE(24), .TIMEOUT(T)) dut (
    .clk(clk), .rstn(rstn), .en(en), .max_scale_cnt(max_scale_cnt),
    .scale_factor(scale_factor), .pic_w_all(pic_w_all), .pic_h_all(pic_h_all),
    .frame_start(frame_start), .scale_done(scale_done),
    .scale_start(scale_start), .scale_idx(scale_idx), .cur_w(cur_w), .cur_h(cur_h),
    .cur_factor(cur_factor), .busy(busy), .frame_ready(frame_ready),
    .frame_drop(frame_drop), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  bit         m_valid = 0;
  bit         m_busy, m_start, m_ready, m_tflag, s_done;
  logic [2:0] m_idx;
  logic [W-1:0] m_w, m_h;
  logic [7:0] m_f;

  task automatic m_clear();
    m_busy = 0; m_start = 0; m_ready = 0; m_tflag = 0;
    m_idx = 0; m_w = 0; m_h = 0; m_f = 0;
  endtask

  task automatic step(output bit ab);
    @(posedge clk);
    s_done = scale_done;
    ab = rstn;
    if (rstn) m_clear();
  endtask

  task automatic run_frame();
    int n, k;
    bit ab;
    n = (max_scale_cnt == 0) ? 1 : (max_scale_cnt > N) ? N : int'(max_scale_cnt);
    m_busy = 1;
    for (int i = 0; i < n; i++) begin
      m_idx = 3'(i);
      step(ab); if (ab) return;
      m_w = pic_w_all[W*i +: W];
      m_h = pic_h_all[W*i +: W];
      m_f = scale_factor[8*i +: 8];
      if (m_w >= 24 && m_h >= 24) begin
        m_start = 1;
        step(ab); if (ab) return;
        m_start = 0;
        k = 1;
        forever begin
          m_tflag = TO_EN && (k == T);
          step(ab); if (ab) return;
          if (s_done || m_tflag) break;
          k++;
        end
        m_tflag = 0;
      end
      step(ab); if (ab) return;
    end
    m_ready = 1;
    step(ab);
    m_ready = 0;
    m_busy = 0;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk);
      if (rstn) begin m_clear(); m_valid = 1; end
      else if (frame_start && en) run_frame();
    end
  end

  // ---------------- compare + monitor ----------------
  int n_start = 0, n_ready = 0, n_drop = 0, n_tout = 0;
  int acc_cyc = 0, tout_cyc = 0;
  int st_idx[$];
  int st_cyc[$];

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, m_busy);
      chk("scale_start", scale_start, m_start);
      chk("frame_ready", frame_ready, m_ready);
      chk("frame_drop", frame_drop, frame_start && m_busy);
      chk("timeout_err", timeout_err, m_tflag && !scale_done);
      chk("scale_idx", scale_idx, m_idx);
      chk("cur_w", cur_w, m_w);
      chk("cur_h", cur_h, m_h);
      chk("cur_factor", cur_factor, m_f);
    end
    if (frame_start && en && !busy && !rstn) acc_cyc = cyc;
    if (scale_start) begin n_start++; st_idx.push_back(int'(scale_idx)); st_cyc.push_back(cyc); end
    if (frame_ready) n_ready++;
    if (frame_drop) n_drop++;
    if (timeout_err) begin n_tout++; tout_cyc = cyc; end
  end

  // scale_done responder: 10 cycles after each start, except the suppressed level
  int no_done_idx = -1;
  initial begin
    scale_done = 0;
    forever begin
      @(negedge clk);
      if (scale_start && int'(scale_idx) != no_done_idx) begin
        repeat (10) @(posedge clk);
        #1 scale_done = 1;
        @(posedge clk);
        #1 scale_done = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int w_tab[N] = '{112, 74, 56, 40, 32};
  int h_tab[N] = '{48, 32, 24, 28, 24};
  int f_tab[N] = '{8'h40, 8'h55, 8'h6A, 8'h80, 8'hA0};

  task automatic load_tabs();
    for (int i = 0; i < N; i++) begin
      pic_w_all[W*i +: W]    = W'(w_tab[i]);
      pic_h_all[W*i +: W]    = W'(h_tab[i]);
      scale_factor[8*i +: 8] = 8'(f_tab[i]);
    end
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
  endtask

  task automatic wait_ready(input string nm, input int budget);
    int r0;
    bit got;
    r0 = n_ready; got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      if (n_ready != r0) got = 1;
    end
    chk(nm, got, 1);
    #1;
  endtask

  task automatic wait_starts(input string nm, input int k, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      if (st_idx.size() >= k) got = 1;
    end
    chk(nm, got, 1);
    #1;
  endtask

  task automatic new_test();
    st_idx.delete();
    st_cyc.delete();
  endtask

  int d0, r0, i0;

  initial begin
    rstn = 1; en = 1; frame_start = 0; max_scale_cnt = 3'd3;
    pic_w_all = '0; pic_h_all = '0; scale_factor = '0;
    load_tabs();
    repeat (3) @(posedge clk);
    #1 chk("reset_busy", busy, 0);
    chk("reset_cur_w", cur_w, 0);
    rstn = 0;
    @(posedge clk); #1;

    // 1: three scales
    new_test();
    pulse_frame();
    wait_ready("t1_ready", 500);
    chk("t1_starts", st_idx.size(), 3);
    if (st_idx.size() == 3) begin
      chk("t1_idx0", st_idx[0], 0);
      chk("t1_idx2", st_idx[2], 2);
      chk("t1_latency", st_cyc[0] - acc_cyc, 2);
    end
    chk("t1_hold_idx", scale_idx, 2);
    chk("t1_hold_w", cur_w, 56);
    chk("t1_hold_h", cur_h, 24);
    chk("t1_hold_f", cur_factor, 8'h6A);

    // 2: level 2 too small
    h_tab[2] = 16; load_tabs();
    new_test();
    r0 = n_ready;
    pulse_frame();
    wait_ready("t2_ready", 500);
    chk("t2_starts", st_idx.size(), 2);
    chk("t2_ready_cnt", n_ready - r0, 1);
    h_tab[2] = 24; load_tabs();

    // 3: frame_start while running is dropped
    new_test();
    pulse_frame();
    wait_starts("t3_first_start", 1, 50);
    repeat (3) @(posedge clk);
    #1 d0 = n_drop; i0 = scale_idx;
    pulse_frame();
    chk("t3_drop", n_drop - d0, 1);
    chk("t3_idx_kept", scale_idx, i0);
    chk("t3_busy", busy, 1);
    wait_ready("t3_ready", 500);
    chk("t3_starts", st_idx.size(), 3);

    // disabled: frame_start ignored, not dropped
    en = 0; new_test(); d0 = n_drop;
    pulse_frame();
    repeat (5) @(posedge clk);
    #1 chk("en0_busy", busy, 0);
    chk("en0_drop", n_drop - d0, 0);
    chk("en0_starts", st_idx.size(), 0);
    en = 1;

    // 4: clamp of max_scale_cnt
    max_scale_cnt = 3'd0; new_test();
    pulse_frame();
    wait_ready("t4a_ready", 500);
    chk("t4a_starts", st_idx.size(), 1);
    max_scale_cnt = 3'd7; new_test();
    pulse_frame();
    wait_ready("t4b_ready", 1000);
    chk("t4b_starts", st_idx.size(), 5);
    if (st_idx.size() == 5) chk("t4b_last_idx", st_idx[4], 4);
    chk("t4b_hold_w", cur_w, 32);

    // 5: reset during RUN at idx 2
    max_scale_cnt = 3'd3; new_test();
    r0 = n_ready;
    pulse_frame();
    wait_starts("t5_third_start", 3, 200);
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(posedge clk); #1 rstn = 0;
    chk("t5_busy", busy, 0);
    chk("t5_idx", scale_idx, 0);
    chk("t5_cur_w", cur_w, 0);
    repeat (20) @(posedge clk);
    #1 chk("t5_no_ready", n_ready - r0, 0);

`ifdef FACE_SCALE_TIMEOUT_EN
    // 6: watchdog on level 1
    no_done_idx = 1; new_test(); d0 = n_tout;
    pulse_frame();
    wait_ready("t6_ready", 1000);
    chk("t6_tout_cnt", n_tout - d0, 1);
    chk("t6_starts", st_idx.size(), 3);
    if (st_idx.size() == 3) chk("t6_tout_lat", tout_cyc - st_cyc[1], 64);
    no_done_idx = -1;
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
